// File: rtl/dma_read_arbiter_pkg.sv
// accel_dma_pkg: shared encodings and defaults for the accelerator DMA arbiters.
// Used by dma_read_arbiter now and the write-back arbiter later.
package accel_dma_pkg;

    localparam int DMA_ADDR_W = 32;
    localparam int DMA_DATA_W = 256;
    localparam int DMA_LEN_W  = 8;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CMD  = 2'b01,
        DATA = 2'b10
    } arb_state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dma_read_arbiter_if.sv
// Handshake bundles around the DMA read arbiter.
// dma_req_if: tile loaders (master) <-> arbiter (slave); dma_rd_if: arbiter (master) <-> engine (slave).
interface dma_req_if
    import accel_dma_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DMA_ADDR_W,
    parameter int DATA_W  = DMA_DATA_W,
    parameter int LEN_W   = DMA_LEN_W
) ();
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_last;
    logic [NUM_REQ-1:0]        rsp_ready;

    modport master (
        output req_valid, req_addr, req_len, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_addr, req_len, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last
    );
endinterface

interface dma_rd_if
    import accel_dma_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W,
    parameter int LEN_W  = DMA_LEN_W
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rlast;
    logic              dma_rready;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, dma_rready,
        input  cmd_ready, dma_rvalid, dma_rdata, dma_rlast
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, dma_rready,
        output cmd_ready, dma_rvalid, dma_rdata, dma_rlast
    );
endinterface

// File: rtl/dma_read_arbiter_rr_select.sv
// rr_select: combinational rotating-priority picker.
// Returns the first set request at or above ptr, wrapping modulo N.
module rr_select #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                idx   = W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/dma_read_arbiter.sv
// dma_read_arbiter: round-robin share of one DMA read channel, one burst in flight.
// Optional DMA_ARB_LEN_CHECK_EN adds a beat counter driving the sticky len_err flag.
module dma_read_arbiter
    import accel_dma_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DMA_ADDR_W,
    parameter int DATA_W  = DMA_DATA_W,
    parameter int LEN_W   = DMA_LEN_W
) (
    input  logic                       clk,
    input  logic                       rstn,
    dma_req_if.slave                   req,
    dma_rd_if.master                   dma,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       len_err
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [LEN_W-1:0]  cmd_len_q;
    logic              cmd_valid_q;

    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic [NUM_REQ-1:0] grant_oh;
    logic               in_data;
    logic               xfer;

    rr_select #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_rr_select (
        .req   (req.req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
        grant_oh          = '0;
        grant_oh[grant_q] = 1'b1;
    end

    assign in_data = (state == DATA);
    assign xfer    = in_data && dma.dma_rvalid && dma.dma_rready;

    // The accept pulse is gated by rstn so nothing is granted while in reset.
    assign req.req_ready = (rstn && state == IDLE && pick_found) ? pick_oh : '0;
    assign req.rsp_valid = (in_data && dma.dma_rvalid) ? grant_oh : '0;
    assign req.rsp_data  = dma.dma_rdata;
    assign req.rsp_last  = dma.dma_rlast;
    assign dma.dma_rready = in_data && req.rsp_ready[grant_q];

    assign dma.cmd_valid = cmd_valid_q;
    assign dma.cmd_addr  = cmd_addr_q;
    assign dma.cmd_len   = cmd_len_q;
    assign grant_id      = grant_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_q     <= pick_idx;
                        cmd_addr_q  <= req.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        cmd_len_q   <= req.req_len[int'(pick_idx)*LEN_W +: LEN_W];
                        cmd_valid_q <= 1'b1;
                        state       <= CMD;
                    end
                end
                CMD: begin
                    if (dma.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (xfer && dma.dma_rlast) begin
                        rr_ptr <= ID_W'(wrap_inc(int'(grant_q), NUM_REQ));
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMA_ARB_LEN_CHECK_EN
    logic [LEN_W:0] beat_cnt;
    logic           len_err_q;

    // A beat is bad when rlast disagrees with "this is beat cmd_len".
    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_cnt  <= '0;
            len_err_q <= 1'b0;
        end else begin
            if (state == CMD && dma.cmd_ready) begin
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + (LEN_W + 1)'(1);
            end
            if (xfer && (dma.dma_rlast != (beat_cnt == {1'b0, cmd_len_q}))) begin
                len_err_q <= 1'b1;
            end
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_dma_read_arbiter.sv
// Directed bench for dma_read_arbiter: grant order, routing, stalls, reset, length check.
module tb_dma_read_arbiter;
    import accel_dma_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 256;
    localparam int LW = 8;

`ifdef DMA_ARB_LEN_CHECK_EN
    localparam logic LEN_ERR_EXP = 1'b1;
`else
    localparam logic LEN_ERR_EXP = 1'b0;
`endif

    logic                 clk;
    logic                 rstn;
    logic [$clog2(N)-1:0] grant_id;
    logic                 busy;
    logic                 len_err;

    int vecs = 0;
    int errs = 0;

    dma_req_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) rq ();
    dma_rd_if  #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) rd ();

    dma_read_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .LEN_W   (LW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (rq),
        .dma      (rd),
        .grant_id (grant_id),
        .busy     (busy),
        .len_err  (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        rq.req_valid  = '0;
        rq.req_addr   = '0;
        rq.req_len    = '0;
        rq.rsp_ready  = '0;
        rd.cmd_ready  = 1'b0;
        rd.dma_rvalid = 1'b0;
        rd.dma_rdata  = '0;
        rd.dma_rlast  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        rq.req_addr[i*AW +: AW] = a;
        rq.req_len[i*LW +: LW]  = l;
    endtask

    task automatic test_reset();
        idle_inputs();
        rq.req_valid = 2'b11;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %0b want 0", busy); end
        vecs++; if (rd.cmd_valid !== 1'b0) begin errs++; $display("FAIL rst_cmd_valid: got %0b want 0", rd.cmd_valid); end
        vecs++; if (rd.cmd_addr !== 32'h0) begin errs++; $display("FAIL rst_cmd_addr: got %0h want 0", rd.cmd_addr); end
        vecs++; if (rd.cmd_len !== 8'h0) begin errs++; $display("FAIL rst_cmd_len: got %0h want 0", rd.cmd_len); end
        vecs++; if (grant_id !== 1'b0) begin errs++; $display("FAIL rst_grant: got %0h want 0", grant_id); end
        vecs++; if (rq.req_ready !== 2'b00) begin errs++; $display("FAIL rst_req_ready: got %b want 00", rq.req_ready); end
        vecs++; if (len_err !== 1'b0) begin errs++; $display("FAIL rst_len_err: got %0b want 0", len_err); end
        rstn = 1'b1;
        rq.req_valid = 2'b00;
    endtask

    task automatic test_single();
        apply_reset();
        set_req(REQ_A, 32'h1000, 8'd1);
        rq.req_valid = 2'b01;
        #1;
        vecs++; if (rq.req_ready !== 2'b01) begin errs++; $display("FAIL single_ready: got %b want 01", rq.req_ready); end
        @(negedge clk);
        rq.req_valid = 2'b00;
        rd.cmd_ready = 1'b1;
        #1;
        vecs++; if (rd.cmd_valid !== 1'b1) begin errs++; $display("FAIL single_cmd_valid: got %0b want 1", rd.cmd_valid); end
        vecs++; if (rd.cmd_addr !== 32'h1000) begin errs++; $display("FAIL single_cmd_addr: got %0h want 1000", rd.cmd_addr); end
        vecs++; if (rd.cmd_len !== 8'd1) begin errs++; $display("FAIL single_cmd_len: got %0h want 1", rd.cmd_len); end
        vecs++; if (rq.req_ready !== 2'b00) begin errs++; $display("FAIL single_ready_drop: got %b want 00", rq.req_ready); end
        @(negedge clk);
        rd.cmd_ready  = 1'b0;
        rd.dma_rvalid = 1'b1;
        rd.dma_rdata  = {8{32'hA5A5_0001}};
        rq.rsp_ready  = 2'b01;
        #1;
        vecs++; if (rd.cmd_valid !== 1'b0) begin errs++; $display("FAIL single_cmd_clr: got %0b want 0", rd.cmd_valid); end
        vecs++; if (rq.rsp_valid !== 2'b01) begin errs++; $display("FAIL single_beat0: got %b want 01", rq.rsp_valid); end
        vecs++; if (rd.dma_rready !== 1'b1) begin errs++; $display("FAIL single_rready: got %0b want 1", rd.dma_rready); end
        vecs++; if (rq.rsp_data !== {8{32'hA5A5_0001}}) begin errs++; $display("FAIL single_data: got %h", rq.rsp_data); end
        @(negedge clk);
        rd.dma_rdata = {8{32'hA5A5_0002}};
        rd.dma_rlast = 1'b1;
        #1;
        vecs++; if (rq.rsp_valid !== 2'b01) begin errs++; $display("FAIL single_beat1: got %b want 01", rq.rsp_valid); end
        vecs++; if (rq.rsp_last !== 1'b1) begin errs++; $display("FAIL single_last: got %0b want 1", rq.rsp_last); end
        @(negedge clk);
        rd.dma_rvalid = 1'b0;
        rd.dma_rlast  = 1'b0;
        #1;
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_idle: got %0b want 0", busy); end
        vecs++; if (len_err !== 1'b0) begin errs++; $display("FAIL single_len_ok: got %0b want 0", len_err); end
        // rr_ptr is now 1, so B wins a tie; then withdraw both before the edge.
        rq.req_valid = 2'b11;
        #1;
        vecs++; if (rq.req_ready !== 2'b10) begin errs++; $display("FAIL single_rr_ptr: got %b want 10", rq.req_ready); end
        rq.req_valid = 2'b00;
        @(negedge clk);
        #1;
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_withdraw: got %0b want 0", busy); end
    endtask

    task automatic test_contention();
        logic       exp_g;
        logic [1:0] exp_oh;
        apply_reset();
        set_req(REQ_A, 32'h2000, 8'd0);
        set_req(REQ_B, 32'h3000, 8'd0);
        rq.req_valid = 2'b11;
        rq.rsp_ready = 2'b11;
        rd.cmd_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            exp_g  = b[0];
            exp_oh = exp_g ? 2'b10 : 2'b01;
            #1;
            vecs++; if (rq.req_ready !== exp_oh) begin errs++; $display("FAIL cont_ready%0d: got %b want %b", b, rq.req_ready, exp_oh); end
            @(negedge clk);
            rd.dma_rvalid = 1'b1;
            rd.dma_rlast  = 1'b1;
            #1;
            vecs++; if (grant_id !== exp_g) begin errs++; $display("FAIL cont_grant%0d: got %0d want %0d", b, grant_id, exp_g); end
            vecs++; if (rd.cmd_addr !== (exp_g ? 32'h3000 : 32'h2000)) begin errs++; $display("FAIL cont_addr%0d: got %0h", b, rd.cmd_addr); end
            vecs++; if (rd.dma_rready !== 1'b0) begin errs++; $display("FAIL cont_cmd_rready%0d: got %0b want 0", b, rd.dma_rready); end
            @(negedge clk);
            #1;
            vecs++; if (rq.rsp_valid !== exp_oh) begin errs++; $display("FAIL cont_rsp%0d: got %b want %b", b, rq.rsp_valid, exp_oh); end
            @(negedge clk);
            rd.dma_rvalid = 1'b0;
            rd.dma_rlast  = 1'b0;
        end
        rq.req_valid = 2'b00;
        rd.cmd_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int beats;
        apply_reset();
        set_req(REQ_B, 32'h4000, 8'd0);
        rq.req_valid = 2'b10;
        #1;
        vecs++; if (rq.req_ready !== 2'b10) begin errs++; $display("FAIL bp_ready: got %b want 10", rq.req_ready); end
        @(negedge clk);
        rq.req_valid = 2'b00;
        rd.cmd_ready = 1'b1;
        #1;
        vecs++; if (grant_id !== 1'b1) begin errs++; $display("FAIL bp_grant: got %0d want 1", grant_id); end
        @(negedge clk);
        rd.cmd_ready  = 1'b0;
        rd.dma_rvalid = 1'b1;
        rd.dma_rlast  = 1'b1;
        rd.dma_rdata  = {8{32'hB0B0_0001}};
        rq.rsp_ready  = 2'b01;
        beats = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vecs++; if (rd.dma_rready !== 1'b0) begin errs++; $display("FAIL bp_stall%0d: got %0b want 0", c, rd.dma_rready); end
            if (rq.rsp_valid[1] && rq.rsp_ready[1]) beats++;
            @(negedge clk);
        end
        rq.rsp_ready = 2'b10;
        #1;
        vecs++; if (rd.dma_rready !== 1'b1) begin errs++; $display("FAIL bp_release: got %0b want 1", rd.dma_rready); end
        vecs++; if (rq.rsp_valid !== 2'b10) begin errs++; $display("FAIL bp_rsp: got %b want 10", rq.rsp_valid); end
        if (rq.rsp_valid[1] && rq.rsp_ready[1]) beats++;
        @(negedge clk);
        #1;
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL bp_done: got %0b want 0", busy); end
        vecs++; if (rd.dma_rready !== 1'b0) begin errs++; $display("FAIL bp_idle_rready: got %0b want 0", rd.dma_rready); end
        vecs++; if (rq.rsp_valid !== 2'b00) begin errs++; $display("FAIL bp_idle_rsp: got %b want 00", rq.rsp_valid); end
        vecs++; if (beats !== 1) begin errs++; $display("FAIL bp_beats: got %0d want 1", beats); end
        idle_inputs();
    endtask

    task automatic test_cmd_stall();
        apply_reset();
        set_req(REQ_A, 32'h5000, 8'd2);
        rq.req_valid = 2'b01;
        @(negedge clk);
        rq.req_valid = 2'b00;
        set_req(REQ_A, 32'hDEAD_0000, 8'hFF);
        rd.dma_rvalid = 1'b1;
        rq.rsp_ready  = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            vecs++; if (rd.cmd_valid !== 1'b1) begin errs++; $display("FAIL stall_valid%0d: got %0b want 1", c, rd.cmd_valid); end
            vecs++; if (rd.cmd_addr !== 32'h5000) begin errs++; $display("FAIL stall_addr%0d: got %0h want 5000", c, rd.cmd_addr); end
            vecs++; if (rd.cmd_len !== 8'd2) begin errs++; $display("FAIL stall_len%0d: got %0h want 2", c, rd.cmd_len); end
            vecs++; if (rq.rsp_valid !== 2'b00) begin errs++; $display("FAIL stall_rsp%0d: got %b want 00", c, rq.rsp_valid); end
            vecs++; if (rd.dma_rready !== 1'b0) begin errs++; $display("FAIL stall_rready%0d: got %0b want 0", c, rd.dma_rready); end
            @(negedge clk);
        end
        rd.cmd_ready = 1'b1;
        @(negedge clk);
        rd.cmd_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            rd.dma_rdata = DW'(b + 16'h0C00);
            rd.dma_rlast = (b == 2);
            #1;
            vecs++; if (rq.rsp_valid !== 2'b01) begin errs++; $display("FAIL stall_beat%0d: got %b want 01", b, rq.rsp_valid); end
            vecs++; if (rq.rsp_data !== DW'(b + 16'h0C00)) begin errs++; $display("FAIL stall_data%0d: got %0h", b, rq.rsp_data); end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL stall_done: got %0b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_req(REQ_A, 32'h6000, 8'd3);
        rq.req_valid = 2'b01;
        @(negedge clk);
        rq.req_valid = 2'b00;
        rd.cmd_ready = 1'b1;
        @(negedge clk);
        rd.cmd_ready  = 1'b0;
        rd.dma_rvalid = 1'b1;
        rq.rsp_ready  = 2'b11;
        @(negedge clk);
        rd.dma_rvalid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %0b want 0", busy); end
        vecs++; if (rd.cmd_valid !== 1'b0) begin errs++; $display("FAIL mid_cmd_valid: got %0b want 0", rd.cmd_valid); end
        vecs++; if (rq.rsp_valid !== 2'b00) begin errs++; $display("FAIL mid_rsp: got %b want 00", rq.rsp_valid); end
        rq.req_valid = 2'b11;
        #1;
        vecs++; if (rq.req_ready !== 2'b01) begin errs++; $display("FAIL mid_rr_ptr: got %b want 01", rq.req_ready); end
        rq.req_valid = 2'b10;
        set_req(REQ_B, 32'h7000, 8'd1);
        #1;
        vecs++; if (rq.req_ready !== 2'b10) begin errs++; $display("FAIL mid_b_ready: got %b want 10", rq.req_ready); end
        @(negedge clk);
        rq.req_valid = 2'b00;
        rd.cmd_ready = 1'b1;
        #1;
        vecs++; if (rd.cmd_addr !== 32'h7000) begin errs++; $display("FAIL mid_b_addr: got %0h want 7000", rd.cmd_addr); end
        vecs++; if (grant_id !== 1'b1) begin errs++; $display("FAIL mid_b_grant: got %0d want 1", grant_id); end
        @(negedge clk);
        rd.cmd_ready  = 1'b0;
        rd.dma_rvalid = 1'b1;
        rq.rsp_ready  = 2'b10;
        #1;
        vecs++; if (rq.rsp_valid !== 2'b10) begin errs++; $display("FAIL mid_b_beat0: got %b want 10", rq.rsp_valid); end
        @(negedge clk);
        rd.dma_rlast = 1'b1;
        #1;
        vecs++; if (rq.rsp_valid !== 2'b10) begin errs++; $display("FAIL mid_b_beat1: got %b want 10", rq.rsp_valid); end
        @(negedge clk);
        idle_inputs();
        #1;
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_b_done: got %0b want 0", busy); end
    endtask

    task automatic test_len_check();
        apply_reset();
        set_req(REQ_A, 32'h8000, 8'd3);
        rq.req_valid = 2'b01;
        @(negedge clk);
        rq.req_valid = 2'b00;
        rd.cmd_ready = 1'b1;
        @(negedge clk);
        rd.cmd_ready  = 1'b0;
        rd.dma_rvalid = 1'b1;
        rq.rsp_ready  = 2'b01;
        repeat (2) @(negedge clk);
        rd.dma_rlast = 1'b1;
        #1;
        vecs++; if (len_err !== 1'b0) begin errs++; $display("FAIL len_pre: got %0b want 0", len_err); end
        @(negedge clk);
        idle_inputs();
        #1;
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL len_end: got %0b want 0", busy); end
        vecs++; if (len_err !== LEN_ERR_EXP) begin errs++; $display("FAIL len_err: got %0b want %0b", len_err, LEN_ERR_EXP); end
        @(negedge clk);
        #1;
        vecs++; if (len_err !== LEN_ERR_EXP) begin errs++; $display("FAIL len_sticky: got %0b want %0b", len_err, LEN_ERR_EXP); end
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_cmd_stall();
        test_reset_mid();
        test_len_check();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/dma_read_arbiter.md
Name: dma_read_arbiter

Overview:
Shares the accelerator's single DMA read channel between NUM_REQ tile loaders (index 0 = A-tile loader, index 1 = B-tile loader).
- Accepts burst read requests, grants them round-robin and issues one command downstream.
- Routes the returned 256-bit beats to the granted requester.
- Only one burst is outstanding at a time.
- Sits between the tile-load control logic and the DMA read engine.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, byte-address width.
- DATA_W, 256, beat width.
- LEN_W, 8, burst length field width; value = beats-1.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester burst request
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- req_addr  in  NUM_REQ*ADDR_W  flattened start addresses; slice i = requester i
- req_len  in  NUM_REQ*LEN_W  flattened beats-1
- cmd_valid  out  1  command to DMA engine
- cmd_ready  in  1  DMA engine accepts command
- cmd_addr  out  ADDR_W  latched address
- cmd_len  out  LEN_W  latched beats-1
- dma_rvalid  in  1  read beat valid
- dma_rdata  in  DATA_W  read beat
- dma_rlast  in  1  last beat of burst
- dma_rready  out  1  beat accepted
- rsp_valid  out  NUM_REQ  beat valid, only the granted bit can be set
- rsp_data  out  DATA_W  shared beat bus (= dma_rdata)
- rsp_last  out  1  = dma_rlast
- rsp_ready  in  NUM_REQ  per-requester beat ready
- grant_id  out  $clog2(NUM_REQ)  current/last grant index
- busy  out  1  high outside IDLE
- len_err  out  1  sticky length-mismatch flag (see Optional Feature)

Behaviour:
- Reset values: all of the following are 0 — state IDLE, rr_ptr, grant_id, req_ready, cmd_valid, cmd_addr, cmd_len, busy, len_err.
- States: IDLE, CMD, DATA.
- IDLE, when any req_valid:
  - Select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register grant_id, cmd_addr and cmd_len from the selected slices.
  - Pulse req_ready[grant] for exactly that cycle.
  - Next state CMD, with cmd_valid=1 registered.
  - The requester must hold addr/len stable while req_valid until req_ready.
- CMD: cmd_valid is held with stable addr/len until cmd_valid & cmd_ready, then cmd_valid <= 0 and go to DATA.
  - Latency from req_valid to cmd_valid: 1 cycle.
- DATA, combinational pass-through:
  - rsp_valid[grant_id] = dma_rvalid; other bits 0.
  - dma_rready = rsp_ready[grant_id].
  - Backpressure propagates with 0-cycle latency.
  - A beat transfers when dma_rvalid & dma_rready.
  - On a transfer with dma_rlast: rr_ptr <= (grant_id+1) mod NUM_REQ, then go to IDLE.
- Outside DATA: rsp_valid = 0 and dma_rready = 0.
- Beats arriving in IDLE or CMD are not accepted.
- A new grant can be issued the cycle after returning to IDLE, so the minimum gap is 1 cycle.
- Fairness: a requester holding req_valid is granted within NUM_REQ bursts.
- Deasserting req_valid before req_ready is legal; the request is simply not granted.
- A single requester repeatedly requesting is granted back-to-back.
- Reset mid-burst (any state): the cycle-after-reset values apply; the partial burst is abandoned. The DMA engine shares rstn and is reset with this block.
- rsp_data and rsp_last always mirror dma_rdata and dma_rlast.

Optional Feature:
- Macro DMA_ARB_LEN_CHECK_EN.
- Defined:
  - A beat counter (LEN_W+1 bits) clears on entry to DATA and increments per transferred beat.
  - len_err is set (sticky until reset) if rlast arrives on a beat index != cmd_len, or a beat with index == cmd_len arrives without rlast.
  - The burst still ends only on rlast.
- Undefined: no counter is built; len_err is tied to 0.

Decomposition:
- Shared package accel_dma_pkg holds:
  - State encodings IDLE=2'b00, CMD=2'b01, DATA=2'b10.
  - Default widths (ADDR_W=32, DATA_W=256, LEN_W=8).
  - Requester index constants REQ_A=0, REQ_B=1.
- One natural sub-module: rr_select, a combinational rotating-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, index.
  - Reusable by the future write-back arbiter.

Test Plan:
- Single request: req_valid=2'b01, addr0=0x1000, len0=1.
  - Expect req_ready[0] pulse, then cmd_valid with cmd_addr=0x1000 and cmd_len=1.
  - After 2 beats with rlast on the 2nd: rsp_valid[0] twice, return to IDLE, rr_ptr=1.
- Contention: both req_valid held from reset, each len=0.
  - Grants must follow 0,1,0,1 over 4 bursts; grant_id matches each cmd.
- Backpressure: rsp_ready[1]=0 for 3 cycles during a B burst with dma_rvalid=1.
  - dma_rready=0 for those 3 cycles; the beat is delivered once when ready rises, with no duplication.
- cmd_ready held low 5 cycles: cmd_valid stays 1 with stable addr/len; no rsp_valid and dma_rready=0 until the command is accepted.
- Reset mid-DATA after 1 of 4 beats:
  - Next cycle busy=0, cmd_valid=0, rr_ptr=0.
  - A fresh request from requester 1 completes normally.
- With DMA_ARB_LEN_CHECK_EN: cmd_len=3 with rlast on beat index 2.
  - len_err=1 the cycle after and stays 1.
  - The burst ends on that rlast.
  - Without the macro, len_err=0.
